nios2_system_nios2_system_oci_dct_packer: RTL and testbench

NIOS2_SYSTEM_NIOS2_SYSTEM_OCI_DCT_PACKER -- requirements
Module: nios2_system_nios2_system_oci_dct_packer

---
 rtl/nios2_system_nios2_system_oci_dct_packer_pkg.sv | 30 +++
 rtl/nios2_system_nios2_system_oci_dct_packer_if.sv | 38 +++
 rtl/nios2_system_nios2_system_oci_dct_slot.sv | 42 ++++
 rtl/nios2_system_nios2_system_oci_dct_packer.sv | 116 +++++++++++
 tb/tb_nios2_system_nios2_system_oci_dct_packer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/nios2_system_nios2_system_oci_dct_packer_pkg.sv
// Shared constants, FSM state type and packet helper for the OCI DCT atom packer.
// Overflow reporting is compiled in with NIOS2_SYSTEM_OCI_DCT_OVF_EN.
package nios2_system_nios2_system_oci_dct_packer_pkg;

    localparam logic [1:0] ATOM_NOT_TAKEN = 2'b00;
    localparam logic [1:0] ATOM_TAKEN     = 2'b01;
    localparam logic [1:0] ATOM_INDIRECT  = 2'b10;
    localparam logic [1:0] ATOM_EXCEPTION = 2'b11;

    localparam logic [1:0] TAG_NORMAL = 2'b10;
    localparam logic [1:0] TAG_OVF    = 2'b11;

    localparam int DCT_MAX_COUNT = 15;
    localparam int BUF_W         = 30;
    localparam int CNT_W         = 4;
    localparam int PKT_W         = 36;

    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        HOLD       = 2'd1,
        HOLD_FLUSH = 2'd2
    } dct_state_e;

    function automatic logic [PKT_W-1:0] packPkt(input logic [1:0]       tag,
                                                 input logic [CNT_W-1:0] cnt,
                                                 input logic [BUF_W-1:0] word);
        return {tag, cnt, word};
    endfunction

endpackage

// File: rtl/nios2_system_nios2_system_oci_dct_packer_if.sv
// Trace-atom input, packet output and status bundle of the DCT packer.
// The dct_ovf status line exists only with NIOS2_SYSTEM_OCI_DCT_OVF_EN.
interface nios2_system_nios2_system_oci_dct_packer_if;
    import nios2_system_nios2_system_oci_dct_packer_pkg::*;

    logic             atom_valid;
    logic [1:0]       atom;
    logic             flush;
    logic             test_ending;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             pkt_valid;
    logic [PKT_W-1:0] pkt_data;
    logic             pkt_ready;
    logic             test_has_ended;
`ifdef NIOS2_SYSTEM_OCI_DCT_OVF_EN
    logic             dct_ovf;

    modport slave (
        input  atom_valid, atom, flush, test_ending, pkt_ready,
        output dct_buffer, dct_count, pkt_valid, pkt_data, test_has_ended, dct_ovf
    );
    modport master (
        output atom_valid, atom, flush, test_ending, pkt_ready,
        input  dct_buffer, dct_count, pkt_valid, pkt_data, test_has_ended, dct_ovf
    );
`else
    modport slave (
        input  atom_valid, atom, flush, test_ending, pkt_ready,
        output dct_buffer, dct_count, pkt_valid, pkt_data, test_has_ended
    );
    modport master (
        output atom_valid, atom, flush, test_ending, pkt_ready,
        input  dct_buffer, dct_count, pkt_valid, pkt_data, test_has_ended
    );
`endif

endinterface

// File: rtl/nios2_system_nios2_system_oci_dct_slot.sv
// Single-entry valid/ready output register holding one closed DCT packet.
// The packer only loads it when the slot is free, so a load always wins.
module nios2_system_nios2_system_oci_dct_slot
    import nios2_system_nios2_system_oci_dct_packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [PKT_W-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [PKT_W-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [PKT_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/nios2_system_nios2_system_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom DCT packets behind a one-entry output slot.
// Define NIOS2_SYSTEM_OCI_DCT_OVF_EN to report dropped atoms via dct_ovf and tag 2'b11.
module nios2_system_nios2_system_oci_dct_packer
    import nios2_system_nios2_system_oci_dct_packer_pkg::*;
(
    input logic clk,
    input logic reset_n,
    nios2_system_nios2_system_oci_dct_packer_if.slave dct_bus
);

    dct_state_e       state_q, state_d;
    logic [BUF_W-1:0] dctBuf_q, dctBuf_d;
    logic [CNT_W-1:0] dctCnt_q, dctCnt_d;
    logic             testSeen_q, testSeen_d;
    logic             testEnded_q, testEnded_d;

    logic             pktValid;
    logic [PKT_W-1:0] pktData;
    logic             slotFree, atomDrop, atomTake, flushReq, closeReq, closeNow;
    logic [BUF_W-1:0] bufNext;
    logic [CNT_W-1:0] cntNext;
    logic [1:0]       closeTag;

    // A 15th atom can only arrive when the slot is free, so a full buffer never waits.
    always_comb begin
        slotFree = !pktValid || dct_bus.pkt_ready;
        atomDrop = dct_bus.atom_valid && !slotFree &&
                   (dctCnt_q == CNT_W'(DCT_MAX_COUNT - 1));
        atomTake = dct_bus.atom_valid && !atomDrop;
        bufNext  = dctBuf_q;
        cntNext  = dctCnt_q;
        if (atomTake) begin
            bufNext[{dctCnt_q, 1'b0} +: 2] = dct_bus.atom;
            cntNext = dctCnt_q + 4'd1;
        end
        flushReq = dct_bus.flush || dct_bus.test_ending || (state_q == HOLD_FLUSH);
        closeReq = (cntNext == CNT_W'(DCT_MAX_COUNT)) || (flushReq && (cntNext != '0));
        closeNow = closeReq && slotFree;
    end

`ifdef NIOS2_SYSTEM_OCI_DCT_OVF_EN
    logic ovfNew_q, ovfNew_d;

    // Drops and closes are mutually exclusive: a drop needs a busy slot, a close a free one.
    always_comb begin
        ovfNew_d = (ovfNew_q || atomDrop) && !closeNow;
        closeTag = ovfNew_q ? TAG_OVF : TAG_NORMAL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovfNew_q <= 1'b0;
        else          ovfNew_q <= ovfNew_d;
    end

    assign dct_bus.dct_ovf = ovfNew_q || (pktValid && (pktData[PKT_W-1 -: 2] == TAG_OVF));
`else
    assign closeTag = TAG_NORMAL;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:
                state_d = closeNow ? HOLD : ACCUM;
            HOLD:
                if (dct_bus.pkt_ready)                          state_d = closeNow ? HOLD : ACCUM;
                else if (dct_bus.flush || dct_bus.test_ending)  state_d = HOLD_FLUSH;
            HOLD_FLUSH:
                if (dct_bus.pkt_ready)                          state_d = closeNow ? HOLD : ACCUM;
            default:
                state_d = ACCUM;
        endcase
    end

    always_comb begin
        dctBuf_d    = closeNow ? '0 : bufNext;
        dctCnt_d    = closeNow ? '0 : cntNext;
        testSeen_d  = testSeen_q || dct_bus.test_ending;
        testEnded_d = testEnded_q ||
                      ((testSeen_q || dct_bus.test_ending) && (dctCnt_q == '0) &&
                       !pktValid && !dct_bus.atom_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            dctBuf_q    <= '0;
            dctCnt_q    <= '0;
            testSeen_q  <= 1'b0;
            testEnded_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dctBuf_q    <= dctBuf_d;
            dctCnt_q    <= dctCnt_d;
            testSeen_q  <= testSeen_d;
            testEnded_q <= testEnded_d;
        end
    end

    nios2_system_nios2_system_oci_dct_slot u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (closeNow),
        .data_i  (packPkt(closeTag, cntNext, bufNext)),
        .ready_i (dct_bus.pkt_ready),
        .valid_o (pktValid),
        .data_o  (pktData)
    );

    assign dct_bus.dct_buffer     = dctBuf_q;
    assign dct_bus.dct_count      = dctCnt_q;
    assign dct_bus.pkt_valid      = pktValid;
    assign dct_bus.pkt_data       = pktData;
    assign dct_bus.test_has_ended = testEnded_q;

endmodule

// File: tb/tb_nios2_system_nios2_system_oci_dct_packer.sv
// Randomised and directed self-checking bench for the DCT packer against a queue-based model.
// Honours NIOS2_SYSTEM_OCI_DCT_OVF_EN for the dct_ovf output and packet tag.
module tb_nios2_system_nios2_system_oci_dct_packer;
    import nios2_system_nios2_system_oci_dct_packer_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nios2_system_nios2_system_oci_dct_packer_if bus ();

    nios2_system_nios2_system_oci_dct_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dct_bus (bus.slave)
    );

    logic [1:0]  mQ[$];
    logic        mValid, mPend, mOvfNew, mSeen, mEnded;
    logic [35:0] mData;

    task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [29:0] packQ();
        logic [29:0] w = '0;
        for (int i = 0; i < mQ.size(); i++) w[2*i +: 2] = mQ[i];
        return w;
    endfunction

    task automatic modelReset();
        mQ.delete();
        mValid = 0; mPend = 0; mOvfNew = 0; mSeen = 0; mEnded = 0; mData = '0;
    endtask

    // One clock of the packer's rules, applied to the atom queue and the slot.
    task automatic modelStep(input logic av, input logic [1:0] a, input logic fl,
                             input logic te, input logic rdy);
        logic free, want;
        logic [1:0] tag;
        if ((mSeen || te) && mQ.size() == 0 && !mValid && !av) mEnded = 1;
        mSeen = mSeen | te;
        free = !mValid || rdy;
        if (av) begin
            if (mQ.size() == 14 && !free) mOvfNew = 1;
            else mQ.push_back(a);
        end
        want = (mQ.size() == 15) || ((fl || te || mPend) && mQ.size() > 0);
        if (free) begin
            if (want) begin
`ifdef NIOS2_SYSTEM_OCI_DCT_OVF_EN
                tag = mOvfNew ? 2'b11 : 2'b10;
`else
                tag = 2'b10;
`endif
                mData = {tag, 4'(mQ.size()), packQ()};
                mQ.delete();
                mOvfNew = 0;
            end
            mValid = want;
            mPend = 0;
        end else if (fl || te) begin
            mPend = 1;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".buffer"}, 36'(bus.dct_buffer), 36'(packQ()));
        checkOutput({tag, ".count"}, 36'(bus.dct_count), 36'(mQ.size()));
        checkOutput({tag, ".valid"}, 36'(bus.pkt_valid), 36'(mValid));
        checkOutput({tag, ".data"}, bus.pkt_data, mData);
        checkOutput({tag, ".ended"}, 36'(bus.test_has_ended), 36'(mEnded));
`ifdef NIOS2_SYSTEM_OCI_DCT_OVF_EN
        checkOutput({tag, ".ovf"}, 36'(bus.dct_ovf),
                    36'(mOvfNew || (mValid && mData[35:34] == 2'b11)));
`endif
    endtask

    // Called at posedge+1; drives one cycle, checks state at the falling edge.
    task automatic applyStimulus(input logic av, input logic [1:0] a, input logic fl,
                                 input logic te, input logic rdy, input string tag);
        bus.atom_valid = av;
        bus.atom = a;
        bus.flush = fl;
        bus.test_ending = te;
        bus.pkt_ready = rdy;
        @(negedge clk);
        checkAll(tag);
        modelStep(av, a, fl, te, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        bus.atom_valid = 0; bus.atom = 0; bus.flush = 0; bus.test_ending = 0; bus.pkt_ready = 0;
        reset_n = 1'b0;
        #2;
        modelReset();
        checkAll(tag);
        checkOutput({tag, ".zero"}, {bus.pkt_data[35:1], bus.pkt_valid}, 36'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.atom_valid = 0; bus.atom = 0; bus.flush = 0; bus.test_ending = 0; bus.pkt_ready = 0;
        @(posedge clk);
        #1;
        doReset("init");

        for (int i = 0; i < 15; i++) applyStimulus(1, ATOM_TAKEN, 0, 0, 1, "full15");
        checkOutput("full15.pkt", bus.pkt_data, {2'b10, 4'd15, 30'h15555555});
        checkOutput("full15.cnt", 36'(bus.dct_count), 36'd0);
        applyStimulus(0, 0, 0, 0, 1, "full15.drain");

        doReset("rst1");
        for (int i = 0; i < 3; i++) applyStimulus(1, ATOM_INDIRECT, 0, 0, 1, "part3");
        applyStimulus(0, 0, 1, 0, 1, "part3.flush");
        checkOutput("part3.pkt", bus.pkt_data, {2'b10, 4'd3, 24'h0, 6'b101010});
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, "part3.after");
        checkOutput("part3.single", 36'(bus.pkt_valid), 36'd0);

        doReset("rst2");
        for (int i = 0; i < 30; i++) applyStimulus(1, ATOM_TAKEN, 0, 0, 0, "ovf30");
        checkOutput("ovf30.hold", bus.pkt_data, {2'b10, 4'd15, 30'h15555555});
        checkOutput("ovf30.cnt", 36'(bus.dct_count), 36'd14);
        applyStimulus(0, 0, 1, 0, 1, "ovf30.flush");
`ifdef NIOS2_SYSTEM_OCI_DCT_OVF_EN
        checkOutput("ovf30.tag", 36'(bus.pkt_data[35:30]), 36'({2'b11, 4'd14}));
`else
        checkOutput("ovf30.tag", 36'(bus.pkt_data[35:30]), 36'({2'b10, 4'd14}));
`endif
        applyStimulus(0, 0, 0, 0, 1, "ovf30.drain");

        doReset("rst3");
        for (int i = 0; i < 15; i++) applyStimulus(1, ATOM_NOT_TAKEN, 0, 0, 0, "pend");
        for (int i = 0; i < 3; i++) applyStimulus(1, ATOM_EXCEPTION, 0, 0, 0, "pend.atoms");
        applyStimulus(0, 0, 1, 0, 0, "pend.flush");
        applyStimulus(0, 0, 0, 0, 0, "pend.wait");
        checkOutput("pend.held", bus.pkt_data, {2'b10, 4'd15, 30'h0});
        applyStimulus(0, 0, 0, 0, 1, "pend.release");
        checkOutput("pend.b2b", {bus.pkt_data[35:1], bus.pkt_valid},
                    {2'b10, 4'd3, 24'h0, 5'b11111, 1'b1});

        doReset("rst4");
        for (int i = 0; i < 22; i++) applyStimulus(1, 2'($urandom), 0, 0, 0, "mid");
        checkOutput("mid.cnt", 36'(bus.dct_count), 36'd7);
        doReset("mid.rst");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, "mid.after");
        checkOutput("mid.nopkt", 36'(bus.pkt_valid), 36'd0);

        doReset("rst5");
        applyStimulus(0, 0, 0, 1, 1, "end");
        checkOutput("end.ended", 36'(bus.test_has_ended), 36'd1);
        checkOutput("end.nopkt", 36'(bus.pkt_valid), 36'd0);

        doReset("rst6");
        for (int i = 0; i < 800; i++)
            applyStimulus(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 5), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
